// File: rtl/mips_defs.sv
// Shared definitions for the E-stage multiply/divide unit: op codes,
// default busy-window lengths and sequencer state encodings.
package mips_defs;

    typedef enum logic [2:0] {
        MD_NONE  = 3'd0,
        MD_MULT  = 3'd1,
        MD_MULTU = 3'd2,
        MD_DIV   = 3'd3,
        MD_DIVU  = 3'd4,
        MD_MTHI  = 3'd5,
        MD_MTLO  = 3'd6
    } md_op_e;

    localparam int MD_MUL_CYCLES = 5;
    localparam int MD_DIV_CYCLES = 10;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } md_state_e;

    function automatic logic md_is_arith(input logic [2:0] op);
        return (op >= 3'd1) && (op <= 3'd4);
    endfunction

    function automatic logic md_is_div(input logic [2:0] op);
        return (op == MD_DIV) || (op == MD_DIVU);
    endfunction

endpackage

// File: rtl/mdu_ctrl_if.sv
// E-stage side of the multiply/divide unit: issue, operands, D-stage
// MD-use hint, and the busy/stall/HI/LO results returned to the pipeline.
interface mdu_ctrl_if;
    logic        start;
    logic [2:0]  op;
    logic [31:0] srcA;
    logic [31:0] srcB;
    logic        md_use_D;
    logic        busy;
    logic        stall_md;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (
        output start, op, srcA, srcB, md_use_D,
        input  busy, stall_md, hi, lo
    );

    modport slave (
        input  start, op, srcA, srcB, md_use_D,
        output busy, stall_md, hi, lo
    );
endinterface

// File: rtl/md_arith.sv
// Combinational 32x32->64 multiply and 32/32 divide for MULT/MULTU/DIV/DIVU.
// div0_o flags a zero divisor so the sequencer can skip the HI/LO commit.
module md_arith
    import mips_defs::*;
(
    input  logic [2:0]  op_i,
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    output logic [31:0] res_hi_o,
    output logic [31:0] res_lo_o,
    output logic        div0_o
);

    logic signed [63:0] a_ext;
    logic signed [63:0] b_ext;
    logic signed [63:0] prod_s;
    logic        [63:0] prod_u;
    logic signed [31:0] a_s;
    logic signed [31:0] bd_s;
    logic signed [31:0] quo_s;
    logic signed [31:0] rem_s;
    logic        [31:0] bd_u;
    logic        [31:0] quo_u;
    logic        [31:0] rem_u;
    logic               div_ovf;

    assign a_ext  = {{32{a_i[31]}}, a_i};
    assign b_ext  = {{32{b_i[31]}}, b_i};
    assign prod_s = a_ext * b_ext;
    assign prod_u = {32'd0, a_i} * {32'd0, b_i};

    // A zero divisor is replaced by 1 so the divider never sees x/0; the
    // result is discarded at commit anyway.
    assign div0_o = (b_i == 32'd0);
    assign bd_u   = div0_o ? 32'd1 : b_i;
    assign a_s    = a_i;
    assign bd_s   = bd_u;

    // INT_MIN / -1 overflows a 32-bit quotient; MIPS wraps it to INT_MIN, rem 0.
    assign div_ovf = (a_i == 32'h8000_0000) && (b_i == 32'hFFFF_FFFF);

    always_comb begin
        quo_s = a_s / bd_s;
        rem_s = a_s % bd_s;
        if (div_ovf) begin
            quo_s = 32'sh8000_0000;
            rem_s = 32'sd0;
        end
    end

    assign quo_u = a_i / bd_u;
    assign rem_u = a_i % bd_u;

    always_comb begin
        res_hi_o = 32'd0;
        res_lo_o = 32'd0;
        case (op_i)
            MD_MULT:  {res_hi_o, res_lo_o} = prod_s;
            MD_MULTU: {res_hi_o, res_lo_o} = prod_u;
            MD_DIV: begin
                res_hi_o = rem_s;
                res_lo_o = quo_s;
            end
            MD_DIVU: begin
                res_hi_o = rem_u;
                res_lo_o = quo_u;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mdu_ctrl.sv
// Multiply/divide sequencer: issues an op, holds busy for a fixed window,
// then commits HI/LO. Also handles MTHI/MTLO and raises the MD stall request.
module mdu_ctrl
    import mips_defs::*;
#(
    parameter int MUL_CYCLES = MD_MUL_CYCLES,
    parameter int DIV_CYCLES = MD_DIV_CYCLES
) (
    input logic       clk,
    input logic       reset,
    mdu_ctrl_if.slave bus
);

    localparam logic [3:0] MUL_CNT = 4'(MUL_CYCLES);
    localparam logic [3:0] DIV_CNT = 4'(DIV_CYCLES);

    md_state_e   state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] pend_hi_q, pend_hi_d;
    logic [31:0] pend_lo_q, pend_lo_d;
    logic        pend_wr_q, pend_wr_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;

    logic [31:0] res_hi;
    logic [31:0] res_lo;
    logic        div0;
    logic        issue;

    md_arith u_arith (
        .op_i     (bus.op),
        .a_i      (bus.srcA),
        .b_i      (bus.srcB),
        .res_hi_o (res_hi),
        .res_lo_o (res_lo),
        .div0_o   (div0)
    );

    assign issue = bus.start && md_is_arith(bus.op);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        pend_hi_d = pend_hi_q;
        pend_lo_d = pend_lo_q;
        pend_wr_d = pend_wr_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        case (state_q)
            S_IDLE: begin
                if (issue) begin
                    state_d   = S_RUN;
                    cnt_d     = md_is_div(bus.op) ? DIV_CNT : MUL_CNT;
                    pend_hi_d = res_hi;
                    pend_lo_d = res_lo;
                    pend_wr_d = !(md_is_div(bus.op) && div0);
                end else if (bus.op == MD_MTHI) begin
                    hi_d = bus.srcA;
                end else if (bus.op == MD_MTLO) begin
                    lo_d = bus.srcA;
                end
            end
            S_RUN: begin
                // New starts and MT writes are ignored while occupied.
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = S_IDLE;
                    if (pend_wr_q) begin
                        hi_d = pend_hi_q;
                        lo_d = pend_lo_q;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= 4'd0;
            pend_hi_q <= 32'd0;
            pend_lo_q <= 32'd0;
            pend_wr_q <= 1'b0;
            hi_q      <= 32'd0;
            lo_q      <= 32'd0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            pend_hi_q <= pend_hi_d;
            pend_lo_q <= pend_lo_d;
            pend_wr_q <= pend_wr_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
        end
    end

    assign bus.busy     = (state_q == S_RUN);
    assign bus.stall_md = bus.md_use_D && (bus.busy || issue);
    assign bus.hi       = hi_q;
    assign bus.lo       = lo_q;

endmodule

// File: tb/tb_mdu_ctrl.sv
// Directed bench for mdu_ctrl: expected HI/LO pairs are queued at issue
// and popped when busy falls.
module tb_mdu_ctrl;
    import mips_defs::*;

    logic clk = 1'b0;
    logic reset;
    int   n_cmp = 0;
    int   n_err = 0;
    logic [63:0] exp_q[$];
    logic [31:0] m_hi, m_lo;

    mdu_ctrl_if bus ();

    mdu_ctrl #(.MUL_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Issue one arithmetic op, count busy cycles, then compare the popped result.
    task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input int n, input logic [63:0] exp);
        int cycles;
        logic [63:0] got;
        exp_q.push_back(exp);
        bus.start = 1'b1;
        bus.op    = op;
        bus.srcA  = a;
        bus.srcB  = b;
        step();
        bus.start = 1'b0;
        bus.op    = MD_NONE;
        cycles = 0;
        while (bus.busy === 1'b1 && cycles < 40) begin
            cycles++;
            step();
        end
        check({tag, "/busy_cycles"}, 32'(cycles), 32'(n));
        check({tag, "/busy_after"}, 32'(bus.busy), 32'd0);
        got = exp_q.pop_front();
        check({tag, "/hi"}, bus.hi, got[63:32]);
        check({tag, "/lo"}, bus.lo, got[31:0]);
        m_hi = got[63:32];
        m_lo = got[31:0];
    endtask

    initial begin
        logic [63:0] got;
        reset        = 1'b0;
        bus.start    = 1'b0;
        bus.op       = MD_NONE;
        bus.srcA     = 32'd0;
        bus.srcB     = 32'd0;
        bus.md_use_D = 1'b0;
        m_hi = 32'd0;
        m_lo = 32'd0;
        step(); step(); step();
        reset = 1'b1;
        step();
        check("rst/busy", 32'(bus.busy), 32'd0);
        check("rst/stall", 32'(bus.stall_md), 32'd0);
        check("rst/hi", bus.hi, 32'd0);
        check("rst/lo", bus.lo, 32'd0);

        // Reset held low for two edges in the middle of a MULT aborts it.
        bus.start = 1'b1; bus.op = MD_MULT; bus.srcA = 32'd3; bus.srcB = 32'd5;
        step();
        bus.start = 1'b0; bus.op = MD_NONE;
        check("abort/busy_run", 32'(bus.busy), 32'd1);
        step();
        reset = 1'b0;
        step(); step();
        reset = 1'b1;
        check("abort/busy", 32'(bus.busy), 32'd0);
        check("abort/hi", bus.hi, 32'd0);
        check("abort/lo", bus.lo, 32'd0);
        repeat (6) step();
        check("abort/hi_late", bus.hi, 32'd0);
        check("abort/lo_late", bus.lo, 32'd0);

        run_op("mult", MD_MULT, 32'hFFFF_FFFE, 32'd3, 5, 64'hFFFF_FFFF_FFFF_FFFA);
        run_op("multu", MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5, 64'hFFFF_FFFE_0000_0001);
        run_op("div", MD_DIV, 32'hFFFF_FFF9, 32'd2, 10, 64'hFFFF_FFFF_FFFF_FFFD);
        run_op("divu0", MD_DIVU, 32'd7, 32'd0, 10, {m_hi, m_lo});
        run_op("div_ovf", MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 10, 64'h0000_0000_8000_0000);
        run_op("divu", MD_DIVU, 32'd100, 32'd7, 10, 64'h0000_0002_0000_000E);

        // MTHI / MTLO in IDLE need no start pulse and never raise busy.
        bus.op = MD_MTHI; bus.srcA = 32'h1234_5678;
        step();
        bus.op = MD_NONE;
        check("mthi/hi", bus.hi, 32'h1234_5678);
        check("mthi/lo", bus.lo, 32'h0000_000E);
        check("mthi/busy", 32'(bus.busy), 32'd0);
        bus.op = MD_MTLO; bus.srcA = 32'hCAFE_BABE;
        step();
        bus.op = MD_NONE;
        check("mtlo/lo", bus.lo, 32'hCAFE_BABE);
        check("mtlo/hi", bus.hi, 32'h1234_5678);
        check("mtlo/busy", 32'(bus.busy), 32'd0);

        // Stall window with an MD op held in D, plus a spurious start mid-RUN.
        bus.md_use_D = 1'b1;
        check("stall/idle", 32'(bus.stall_md), 32'd0);
        exp_q.push_back(64'h0000_0000_0000_0014);
        bus.start = 1'b1; bus.op = MD_MULT; bus.srcA = 32'd4; bus.srcB = 32'd5;
        #1;
        check("stall/issue", 32'(bus.stall_md), 32'd1);
        step();
        bus.start = 1'b0; bus.op = MD_NONE;
        check("stall/c1", 32'(bus.stall_md), 32'd1);
        step();
        check("stall/c2", 32'(bus.stall_md), 32'd1);
        bus.start = 1'b1; bus.op = MD_MULTU; bus.srcA = 32'd100; bus.srcB = 32'd100;
        step();
        bus.start = 1'b0; bus.op = MD_NONE;
        check("stall/c3", 32'(bus.stall_md), 32'd1);
        step();
        check("stall/c4", 32'(bus.stall_md), 32'd1);
        step();
        check("stall/c5", 32'(bus.stall_md), 32'd1);
        check("stall/busy5", 32'(bus.busy), 32'd1);
        step();
        check("stall/c6", 32'(bus.stall_md), 32'd0);
        check("stall/busy6", 32'(bus.busy), 32'd0);
        got = exp_q.pop_front();
        check("stall/hi", bus.hi, got[63:32]);
        check("stall/lo", bus.lo, got[31:0]);
        repeat (3) step();
        check("stall/no_rerun", 32'(bus.busy), 32'd0);
        check("stall/lo_held", bus.lo, 32'h0000_0014);
        bus.md_use_D = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
